// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory/writeback boundary: opcode encoding and the
// queued MEM/WB entry layout at the default datapath widths.
package cpu_types_pkg;

  localparam int WORD_W   = 32;
  localparam int REGSEL_W = 5;

  typedef enum logic [5:0] {
    OP_NOP   = 6'h00,
    OP_ALU   = 6'h01,
    OP_ALUI  = 6'h02,
    OP_LOAD  = 6'h03,
    OP_STORE = 6'h04,
    OP_BR    = 6'h05,
    OP_JMP   = 6'h06,
    OP_HALT  = 6'h3f
  } opcode_t;

  typedef struct packed {
    logic [WORD_W-1:0]   dload;
    logic [WORD_W-1:0]   alu;
    logic                reg_wr;
    logic [REGSEL_W-1:0] wsel;
    logic                write_sig;
    logic                halt;
    opcode_t             opcode;
  } memwb_entry_t;

endpackage

// File: rtl/mem_wb_slot.sv
// One MEM/WB queue entry: registered payload plus an occupancy bit.
// clr (flush) overrides a write; the controller never writes and reads one slot together.
module mem_wb_slot
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] dload_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic              reg_wr_in,
  input  logic [REG_W-1:0]  wsel_in,
  input  logic              write_sig_in,
  input  logic              halt_in,
  input  opcode_t           opcode_in,
  output logic              valid,
  output logic [DATA_W-1:0] dload,
  output logic [DATA_W-1:0] alu,
  output logic              reg_wr,
  output logic [REG_W-1:0]  wsel,
  output logic              write_sig,
  output logic              halt,
  output opcode_t           opcode
);

  localparam int PW = 2 * DATA_W + REG_W + 3 + 6;

  logic          valid_q, valid_d;
  logic [PW-1:0] payload_q, payload_d;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (wr_en) begin
      valid_d   = 1'b1;
      payload_d = {dload_in, alu_in, reg_wr_in, wsel_in, write_sig_in, halt_in, 6'(opcode_in)};
    end else if (rd_en) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid = valid_q;
  assign {dload, alu, reg_wr, wsel, write_sig, halt} = payload_q[PW-1:6];
  assign opcode = opcode_t'(payload_q[5:0]);

endmodule

// File: rtl/mem_wb_buffer.sv
// Elastic MEM/WB queue: DEPTH slots in a circular buffer with valid/ready, flush and halt lock.
// Define MEMWB_FWD_EN to add the youngest-writer forwarding outputs (fwd_valid/fwd_sel/fwd_data).
module mem_wb_buffer
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          dloadi,
  input  logic [DATA_W-1:0]          alui,
  input  logic                       reg_wri,
  input  logic [REG_W-1:0]           wseli,
  input  logic                       write_sigi,
  input  logic                       halti,
  input  opcode_t                    opcodei,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          dloado,
  output logic [DATA_W-1:0]          aluo,
  output logic                       reg_wro,
  output logic [REG_W-1:0]           wselo,
  output logic                       write_sigo,
  output logic                       halto,
  output opcode_t                    opcodeo,
  output logic [DATA_W-1:0]          wdat,
  output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef MEMWB_FWD_EN
  output logic                       fwd_valid,
  output logic [REG_W-1:0]           fwd_sel,
  output logic [DATA_W-1:0]          fwd_data,
`endif
  output logic                       halted
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q, halted_d;
  logic             push, pop;

  logic              s_valid     [DEPTH];
  logic [DATA_W-1:0] s_dload     [DEPTH];
  logic [DATA_W-1:0] s_alu       [DEPTH];
  logic              s_reg_wr    [DEPTH];
  logic [REG_W-1:0]  s_wsel      [DEPTH];
  logic              s_write_sig [DEPTH];
  logic              s_halt      [DEPTH];
  opcode_t           s_opcode    [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // in_ready depends only on state, so a full queue refuses a push even while popping.
  assign in_ready  = (count_q < CNT_W'(DEPTH)) && !halted_q;
  assign out_valid = s_valid[head_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push && halti) halted_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    mem_wb_slot #(.DATA_W(DATA_W), .REG_W(REG_W)) u_slot (
      .CLK          (CLK),
      .RST          (RST),
      .clr          (flush),
      .wr_en        (push && !flush && (tail_q == PTR_W'(gi))),
      .rd_en        (pop && !flush && (head_q == PTR_W'(gi))),
      .dload_in     (dloadi),
      .alu_in       (alui),
      .reg_wr_in    (reg_wri),
      .wsel_in      (wseli),
      .write_sig_in (write_sigi),
      .halt_in      (halti),
      .opcode_in    (opcodei),
      .valid        (s_valid[gi]),
      .dload        (s_dload[gi]),
      .alu          (s_alu[gi]),
      .reg_wr       (s_reg_wr[gi]),
      .wsel         (s_wsel[gi]),
      .write_sig    (s_write_sig[gi]),
      .halt         (s_halt[gi]),
      .opcode       (s_opcode[gi])
    );
  end

  // An empty queue presents a bubble: every head field reads zero.
  assign dloado     = out_valid ? s_dload[head_q]     : '0;
  assign aluo       = out_valid ? s_alu[head_q]       : '0;
  assign reg_wro    = out_valid && s_reg_wr[head_q];
  assign wselo      = out_valid ? s_wsel[head_q]      : '0;
  assign write_sigo = out_valid && s_write_sig[head_q];
  assign halto      = out_valid && s_halt[head_q];
  assign opcodeo    = out_valid ? s_opcode[head_q]    : OP_NOP;
  assign wdat       = write_sigo ? dloado : aluo;
  assign count      = count_q;
  assign halted     = halted_q;

`ifdef MEMWB_FWD_EN
  logic [PTR_W-1:0] fwd_idx;
  int               fwd_pos;
  logic             fwd_found;

  // Walk from the newest slot (tail-1) toward the oldest; the first writer wins.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_sel   = '0;
    fwd_data  = '0;
    fwd_found = 1'b0;
    fwd_pos   = 0;
    fwd_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_pos = int'(tail_q) + DEPTH - 1 - k;
      if (fwd_pos >= DEPTH) fwd_pos = fwd_pos - DEPTH;
      fwd_idx = PTR_W'(fwd_pos);
      if (!fwd_found && s_valid[fwd_idx] && s_reg_wr[fwd_idx]) begin
        fwd_found = 1'b1;
        fwd_sel   = s_wsel[fwd_idx];
        fwd_data  = s_write_sig[fwd_idx] ? s_dload[fwd_idx] : s_alu[fwd_idx];
        fwd_valid = (s_wsel[fwd_idx] != '0);
      end
    end
  end
`endif

endmodule
